// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, credit-tracked write arbiter for one sync_fifo write port
// Optional multi-beat grants are compiled in with FIFO_ARB_BURST_EN.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            fifo_rd_done,
    output logic                            fifo_wr_en,
    output logic [DATA_WIDTH-1:0]           fifo_wr_data,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] credits,
    output logic                            almost_full,
    output logic                            credit_err
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_LVL  = CW'(FIFO_DEPTH / 4);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_cfg
        $error("fifo_wr_arbiter: parameter out of range");
    end

    logic [IDW-1:0]        rr_ptr_q;
    logic [CW-1:0]         credits_q, credits_d;
    logic                  wr_en_q, af_q, err_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [IDW-1:0]        grant_q;
    logic [IDW-1:0]        win, acc_id;
    logic                  any_valid, accept, rd_ok;

`ifdef FIFO_ARB_BURST_EN
    localparam int BW = $clog2(MAX_BURST + 1);
    typedef enum logic {IDLE, BURST} state_t;
    state_t          state_q;
    logic [IDW-1:0]  owner_q;
    logic [BW-1:0]   beat_q;
`endif

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // Scan downwards so the lowest offset from rr_ptr_q is the last one written.
    always_comb begin
        win       = rr_ptr_q;
        any_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[IDW'((int'(rr_ptr_q) + k) % NUM_REQ)]) begin
                win       = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        acc_id    = win;
`ifdef FIFO_ARB_BURST_EN
        if (state_q == BURST) begin
            acc_id = owner_q;
        end
        if (!rst && credits_q != '0) begin
            if (state_q == BURST) begin
                req_ready[owner_q] = 1'b1;
            end else if (any_valid) begin
                req_ready[win] = 1'b1;
            end
        end
`else
        if (!rst && credits_q != '0 && any_valid) begin
            req_ready[win] = 1'b1;
        end
`endif
    end

    assign accept    = |(req_valid & req_ready);
    assign rd_ok     = fifo_rd_done && (credits_q != DEPTH_C);
    assign credits_d = credits_q - CW'(accept) + CW'(rd_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            credits_q <= DEPTH_C;
            af_q      <= 1'b0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
`ifdef FIFO_ARB_BURST_EN
            state_q   <= IDLE;
            owner_q   <= '0;
            beat_q    <= '0;
`endif
        end else begin
            credits_q <= credits_d;
            af_q      <= (credits_d <= AF_LVL);
            if (fifo_rd_done && !rd_ok) begin
                err_q <= 1'b1;
            end
            wr_en_q <= accept;
            if (accept) begin
                wr_data_q <= req_data[int'(acc_id)*DATA_WIDTH +: DATA_WIDTH];
                grant_q   <= acc_id;
            end
`ifdef FIFO_ARB_BURST_EN
            if (state_q == IDLE) begin
                if (accept) begin
                    if (MAX_BURST > 1) begin
                        state_q <= BURST;
                        owner_q <= win;
                        beat_q  <= BW'(1);
                    end else begin
                        rr_ptr_q <= next_idx(win);
                    end
                end
            end else if (!req_valid[owner_q]) begin
                state_q  <= IDLE;
                rr_ptr_q <= next_idx(owner_q);
            end else if (accept) begin
                beat_q <= beat_q + 1'b1;
                if (beat_q + 1'b1 == BW'(MAX_BURST)) begin
                    state_q  <= IDLE;
                    rr_ptr_q <= next_idx(owner_q);
                end
            end
`else
            if (accept) begin
                rr_ptr_q <= next_idx(win);
            end
`endif
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign grant_id     = grant_q;
    assign credits      = credits_q;
    assign almost_full  = af_q;
    assign credit_err   = err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter (either FIFO_ARB_BURST_EN setting)
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int MB    = 4;
`ifdef FIFO_ARB_BURST_EN
    localparam bit BURST_MODE = 1'b1;
`else
    localparam bit BURST_MODE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          fifo_rd_done;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_wr_data;
    logic [1:0]    grant_id;
    logic [4:0]    credits;
    logic          almost_full;
    logic          credit_err;

    int checks = 0;
    int errors = 0;

    // Reference model: free entries, rotation pointer, burst owner (-1 = none)
    int m_cred = DEPTH, m_ptr = 0, m_owner = -1, m_beats = 0;
    bit m_err = 1'b0;
    bit exp_wr = 1'b0;
    int exp_id = 0;
    logic [DW-1:0] exp_data = '0;
    int wr_log[$];

    fifo_wr_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_rd_done(fifo_rd_done),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .grant_id(grant_id),
        .credits(credits), .almost_full(almost_full), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    task automatic run_cycle();
        int w, id, old;
        logic [N-1:0] exp_rdy, vld;
        logic [N*DW-1:0] dat;
        bit acc, rd, rs;
        #1;
        vld = req_valid; dat = req_data; rd = fifo_rd_done; rs = rst;
        w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && vld[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        exp_rdy = '0;
        if (!rs && m_cred > 0) begin
            if (m_owner >= 0) exp_rdy[m_owner] = 1'b1;
            else if (w >= 0) exp_rdy[w] = 1'b1;
        end
        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL req_ready act=%b exp=%b t=%0t", req_ready, exp_rdy, $time);
        end
        acc = |(vld & exp_rdy);
        id = (m_owner >= 0) ? m_owner : w;
        @(posedge clk);
        #1;
        if (rs) begin
            m_cred = DEPTH; m_ptr = 0; m_owner = -1; m_beats = 0; m_err = 1'b0;
            exp_wr = 1'b0; exp_id = 0; exp_data = '0;
        end else begin
            exp_wr = acc;
            if (acc) begin
                exp_id = id;
                exp_data = dat[id*DW +: DW];
                wr_log.push_back(id);
            end
            old = m_cred;
            if (rd && old == DEPTH) m_err = 1'b1;
            m_cred = old - int'(acc) + int'(rd && old != DEPTH);
            if (m_owner >= 0) begin
                if (!vld[m_owner]) begin
                    m_ptr = (m_owner + 1) % N; m_owner = -1;
                end else if (acc) begin
                    m_beats++;
                    if (m_beats == MB) begin m_ptr = (m_owner + 1) % N; m_owner = -1; end
                end
            end else if (acc) begin
                if (BURST_MODE && MB > 1) begin m_owner = w; m_beats = 1; end
                else m_ptr = (w + 1) % N;
            end
        end
        checks++;
        if (fifo_wr_en !== exp_wr) begin
            errors++; $display("FAIL wr_en act=%b exp=%b t=%0t", fifo_wr_en, exp_wr, $time);
        end
        if (exp_wr) begin
            checks += 2;
            if (fifo_wr_data !== exp_data) begin
                errors++; $display("FAIL wr_data act=%h exp=%h t=%0t", fifo_wr_data, exp_data, $time);
            end
            if (grant_id !== 2'(exp_id)) begin
                errors++; $display("FAIL grant_id act=%0d exp=%0d t=%0t", grant_id, exp_id, $time);
            end
        end
        checks += 3;
        if (credits !== 5'(m_cred)) begin
            errors++; $display("FAIL credits act=%0d exp=%0d t=%0t", credits, m_cred, $time);
        end
        if (almost_full !== (m_cred <= DEPTH / 4)) begin
            errors++; $display("FAIL almost_full act=%b exp=%b t=%0t", almost_full, (m_cred <= DEPTH / 4), $time);
        end
        if (credit_err !== m_err) begin
            errors++; $display("FAIL credit_err act=%b exp=%b t=%0t", credit_err, m_err, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; fifo_rd_done = 1'b0;
        run_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; fifo_rd_done = 1'b0; req_data = 32'h13121110;
        run_cycle();
        run_cycle();
        checks++;
        if ({fifo_wr_en, fifo_wr_data, grant_id, credits, almost_full, credit_err} !== {1'b0, 8'h00, 2'd0, 5'd16, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values act=%b/%h/%0d/%0d/%b/%b exp=0/00/0/16/0/0",
                     fifo_wr_en, fifo_wr_data, grant_id, credits, almost_full, credit_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_fill();
        int e;
        do_reset();
        req_valid = '1; req_data = 32'h13121110;
        wr_log.delete();
        for (int c = 0; c < 24; c++) run_cycle();
        checks++;
        if (wr_log.size() != 16) begin
            errors++; $display("FAIL fill_count act=%0d exp=16", wr_log.size());
        end
        for (int j = 0; j < 16 && j < wr_log.size(); j++) begin
            e = BURST_MODE ? j / MB : j % N;
            checks++;
            if (wr_log[j] != e) begin
                errors++; $display("FAIL fill_order beat=%0d act=%0d exp=%0d", j, wr_log[j], e);
            end
        end
        checks++;
        if (credits !== 5'd0 || req_ready !== 4'b0000 || almost_full !== 1'b1) begin
            errors++;
            $display("FAIL fill_end act=cred %0d rdy %b af %b exp=cred 0 rdy 0000 af 1", credits, req_ready, almost_full);
        end
    endtask

    task automatic test_one_credit();
        req_valid = 4'b0100; fifo_rd_done = 1'b1;
        wr_log.delete();
        run_cycle();
        checks++;
        if (credits !== 5'd1) begin
            errors++; $display("FAIL one_credit_inc act=%0d exp=1", credits);
        end
        fifo_rd_done = 1'b0;
        for (int c = 0; c < 5; c++) run_cycle();
        checks++;
        if (wr_log.size() != 1 || (wr_log.size() == 1 && wr_log[0] != 2) || credits !== 5'd0) begin
            errors++; $display("FAIL one_credit act=%0d beats cred %0d exp=1 beat from 2 cred 0", wr_log.size(), credits);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        req_valid = 4'b0001; req_data = 32'h000000A5;
        for (int c = 0; c < 11; c++) run_cycle();
        checks++;
        if (credits !== 5'd5) begin
            errors++; $display("FAIL pre_same_cycle act=%0d exp=5", credits);
        end
        fifo_rd_done = 1'b1;
        run_cycle();
        fifo_rd_done = 1'b0;
        checks++;
        if (credits !== 5'd5 || fifo_wr_en !== 1'b1) begin
            errors++; $display("FAIL same_cycle act=cred %0d wr %b exp=cred 5 wr 1", credits, fifo_wr_en);
        end
    endtask

    task automatic test_drop_valid();
        do_reset();
        req_data = 32'h00B2A1C0;
        req_valid = 4'b0010;
        wr_log.delete();
        run_cycle();
        run_cycle();
        req_valid = 4'b0101;
        for (int c = 0; c < 3; c++) run_cycle();
        checks++;
        if (wr_log.size() < 3) begin
            errors++; $display("FAIL drop_count act=%0d exp=3 or more", wr_log.size());
        end else if (wr_log[0] != 1 || wr_log[1] != 1 || wr_log[2] != 2) begin
            errors++; $display("FAIL drop_order act=%0d,%0d,%0d exp=1,1,2", wr_log[0], wr_log[1], wr_log[2]);
        end
    endtask

    task automatic test_err_and_reset();
        do_reset();
        fifo_rd_done = 1'b1;
        run_cycle();
        fifo_rd_done = 1'b0;
        checks++;
        if (credit_err !== 1'b1 || credits !== 5'd16) begin
            errors++; $display("FAIL credit_err_set act=err %b cred %0d exp=err 1 cred 16", credit_err, credits);
        end
        req_valid = '1; req_data = 32'h44332211;
        for (int c = 0; c < 3; c++) run_cycle();
        checks++;
        if (credit_err !== 1'b1) begin
            errors++; $display("FAIL credit_err_sticky act=%b exp=1", credit_err);
        end
        rst = 1'b1;
        run_cycle();
        checks++;
        if ({fifo_wr_en, fifo_wr_data, grant_id, credits, almost_full, credit_err} !== {1'b0, 8'h00, 2'd0, 5'd16, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_burst_reset act=%b/%h/%0d/%0d/%b/%b exp=0/00/0/16/0/0",
                     fifo_wr_en, fifo_wr_data, grant_id, credits, almost_full, credit_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req_valid    = 4'($urandom & $urandom);
            if ($urandom_range(0, 3) == 0) req_valid = req_valid | 4'($urandom);
            req_data     = $urandom;
            fifo_rd_done = ($urandom_range(0, 9) < 5);
            rst          = ($urandom_range(0, 199) == 0);
            run_cycle();
        end
        rst = 1'b0; fifo_rd_done = 1'b0; req_valid = '0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; fifo_rd_done = 1'b0;
        test_reset();
        test_fill();
        test_one_credit();
        test_same_cycle();
        test_drop_valid();
        test_err_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
